// File: rtl/fetch_unit.sv
// Instruction fetch unit: program counter, next-PC selection and a
// two-state fetch FSM that captures the instruction register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWre,
  input  logic        IRWre,
  input  logic [1:0]  Branch,
  input  logic [31:0] ExtImm,
  input  logic [31:0] JumpReg,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [15:0] imm16,
  output logic        busy,
  output logic        fetch_done,
  output logic        misalign
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_start;
  logic        w_end;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] r_pp4;
  logic [31:0] r_addr;
  logic        r_done;
  logic        r_mis;
  logic [31:0] w_seq;
  logic [31:0] w_npc;
  logic        w_jr_bad;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_end       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (IRWre) begin
          w_state_nxt = S_WAIT;
          w_start     = 1'b1;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          w_state_nxt = S_IDLE;
          w_end       = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_seq = r_pc + 32'd4;

  // Jump target takes its upper nibble from the last fetch's link value.
  always_comb begin
    w_npc = w_seq;
    unique case (Branch)
      2'b00: w_npc = w_seq;
      2'b01: w_npc = w_seq + (ExtImm << 2);
      2'b10: w_npc = {r_pp4[31:28], r_ir[25:0], 2'b00};
      2'b11: w_npc = {JumpReg[31:2], 2'b00};
      default: w_npc = w_seq;
    endcase
  end

  assign w_jr_bad = PCWre && (Branch == 2'b11) &&
                    (JumpReg[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_ir    <= 32'h0;
      r_pp4   <= 32'h0;
      r_addr  <= 32'h0;
      r_done  <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_end;
      if (PCWre)
        r_pc <= w_npc;
      if (w_start)
        r_addr <= r_pc;
      if (w_end) begin
        r_ir  <= imem_rdata;
        r_pp4 <= r_addr + 32'd4;
      end
      if (w_jr_bad)
        r_mis <= 1'b1;
    end
  end

  assign busy       = (r_state == S_WAIT);
  assign imem_req   = busy;
  assign imem_addr  = busy ? r_addr : 32'h0;
  assign PC         = r_pc;
  assign PCPlus4    = r_pp4;
  assign fetch_done = r_done;
  assign misalign   = r_mis;
  assign op         = r_ir[31:26];
  assign rs         = r_ir[25:21];
  assign rt         = r_ir[20:16];
  assign rd         = r_ir[15:11];
  assign shamt      = r_ir[10:6];
  assign func       = r_ir[5:0];
  assign imm16      = r_ir[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// traffic compared every cycle against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWre = 1'b0;
  logic        IRWre = 1'b0;
  logic [1:0]  Branch = 2'b00;
  logic [31:0] ExtImm = 32'h0;
  logic [31:0] JumpReg = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_ack = 1'b0;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [5:0]  op;
  logic [5:0]  func;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [15:0] imm16;
  logic        busy;
  logic        fetch_done;
  logic        misalign;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .PCWre(PCWre), .IRWre(IRWre),
    .Branch(Branch), .ExtImm(ExtImm), .JumpReg(JumpReg),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .PC(PC), .PCPlus4(PCPlus4), .op(op), .func(func),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm16(imm16),
    .busy(busy), .fetch_done(fetch_done), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Behavioural model: a pending fetch is just "busy + address".
  logic [31:0] m_pc, m_ir, m_pp4, m_addr;
  logic        m_busy, m_done, m_mis;

  function automatic logic [31:0] target(
    input logic [1:0] br, input logic [31:0] pc,
    input logic [31:0] ext, input logic [31:0] jr,
    input logic [31:0] ir, input logic [31:0] pp4);
    logic [31:0] t;
    case (br)
      2'd0: t = pc + 32'd4;
      2'd1: t = pc + 32'd4 + ext * 32'd4;
      2'd2: t = (pp4 & 32'hF000_0000) | ((ir & 32'h03FF_FFFF) * 32'd4);
      default: t = jr & 32'hFFFF_FFFC;
    endcase
    return t;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc = 0; m_ir = 0; m_pp4 = 0; m_addr = 0;
      m_busy = 0; m_done = 0; m_mis = 0;
    end else begin
      logic [31:0] old_pc;
      old_pc = m_pc;
      m_done = 1'b0;
      if (PCWre) begin
        m_pc = target(Branch, old_pc, ExtImm, JumpReg, m_ir, m_pp4);
        if (Branch == 2'd3 && JumpReg[1:0] != 0) m_mis = 1'b1;
      end
      if (m_busy) begin
        if (imem_ack) begin
          m_ir = imem_rdata;
          m_pp4 = m_addr + 32'd4;
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (IRWre) begin
        m_busy = 1'b1;
        m_addr = old_pc;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_all();
    chk("PC", PC, m_pc);
    chk("PCPlus4", PCPlus4, m_pp4);
    chk("IRfields", {op, rs, rt, rd, shamt, func}, m_ir);
    chk("imm16", {16'h0, imm16}, {16'h0, m_ir[15:0]});
    chk("busy", {31'h0, busy}, {31'h0, m_busy});
    chk("imem_req", {31'h0, imem_req}, {31'h0, m_busy});
    chk("imem_addr", imem_addr, m_busy ? m_addr : 32'h0);
    chk("fetch_done", {31'h0, fetch_done}, {31'h0, m_done});
    chk("misalign", {31'h0, misalign}, {31'h0, m_mis});
  endtask

  task automatic step(input logic pcw, input logic irw,
                      input logic [1:0] br, input logic [31:0] ext,
                      input logic [31:0] jr, input logic [31:0] rd_,
                      input logic ack);
    PCWre = pcw; IRWre = irw; Branch = br; ExtImm = ext;
    JumpReg = jr; imem_rdata = rd_; imem_ack = ack;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    step(0, 0, 2'd0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_all();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic jr_to(input logic [31:0] a);
    step(1, 0, 2'd3, 0, a, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    check_all();
    chk("reset_pc", PC, 32'h0);
    rst = 1'b0;

    // Fetch with ack after three wait cycles
    step(0, 1, 2'd0, 0, 0, 0, 0);
    chk("wait_addr0", imem_addr, 32'h0);
    chk("wait_req", {31'h0, imem_req}, 32'h1);
    step(0, 0, 2'd0, 0, 0, 0, 0);
    step(0, 0, 2'd0, 0, 0, 0, 0);
    chk("wait_addr2", imem_addr, 32'h0);
    step(0, 0, 2'd0, 0, 0, 32'h2008_0005, 1);
    chk("op", {26'h0, op}, 32'h08);
    chk("rt", {27'h0, rt}, 32'h8);
    chk("imm16_lit", {16'h0, imm16}, 32'h5);
    chk("pp4_lit", PCPlus4, 32'h4);
    chk("done_hi", {31'h0, fetch_done}, 32'h1);
    idle();
    chk("done_lo", {31'h0, fetch_done}, 32'h0);

    // Branch with negative offset and sequential wrap
    jr_to(32'h100);
    step(1, 0, 2'd1, 32'hFFFF_FFFE, 0, 0, 0);
    chk("branch_neg", PC, 32'h0FC);
    jr_to(32'hFFFF_FFFC);
    step(1, 0, 2'd0, 0, 0, 0, 0);
    chk("seq_wrap", PC, 32'h0);

    // Jump uses IR and PCPlus4 of the last fetch
    jr_to(32'h1000_0000);
    step(0, 1, 2'd0, 0, 0, 0, 0);
    step(0, 0, 2'd0, 0, 0, 32'h0800_0040, 1);
    step(1, 0, 2'd2, 0, 0, 0, 0);
    chk("jump", PC, 32'h1000_0100);

    // IRWre and PCWre during WAIT
    step(0, 1, 2'd0, 0, 0, 0, 0);
    step(1, 1, 2'd0, 0, 0, 0, 0);
    chk("wait_pc_adv", PC, 32'h1000_0104);
    chk("wait_addr_hold", imem_addr, 32'h1000_0100);
    step(0, 1, 2'd0, 0, 0, 32'h1234_5678, 1);
    chk("single_req", {31'h0, busy}, 32'h0);
    idle();
    chk("no_requeue", {31'h0, busy}, 32'h0);

    // Misaligned jr target is sticky until reset
    jr_to(32'h0000_0203);
    chk("jr_align", PC, 32'h200);
    chk("mis_set", {31'h0, misalign}, 32'h1);
    step(0, 1, 2'd0, 0, 0, 0, 0);
    step(0, 0, 2'd0, 0, 0, 32'hDEAD_BEEF, 1);
    idle();
    chk("mis_sticky", {31'h0, misalign}, 32'h1);

    // Reset mid-WAIT, then a stray ack
    step(0, 1, 2'd0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check_all();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_ir", {op, rs, rt, rd, shamt, func}, 32'h0);
    chk("rst_mis", {31'h0, misalign}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 2'd0, 0, 0, 32'hFFFF_FFFF, 1);
    chk("stray_done", {31'h0, fetch_done}, 32'h0);
    chk("stray_ir", {op, rs, rt, rd, shamt, func}, 32'h0);
    step(0, 1, 2'd0, 0, 0, 0, 0);
    chk("post_rst_fetch", {31'h0, busy}, 32'h1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if (i % 97 == 50) begin
        do_reset();
      end else begin
        step($urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0,
             2'($urandom_range(0, 3)),
             $urandom, $urandom, $urandom,
             $urandom_range(0, 2) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
